ipv4_tx_pkt_arbiter: RTL and testbench

Packet-granular round-robin arbiter that merges the UDP and ICMP transmit packet streams into a single IPv4 byte stream toward the Ethernet TX MAC framer. It is the transmit-side counterpart of `ipv4_pkt_router`: each source presents whole packets over the same rdy/byte/vld/last/rd byte interface, and the arbiter grants one source for the full packet. It also enforces a maximum packet length, detects stalled sources and keeps per-source packet counters for the status register block.

---
 rtl/ipv4_tx_pkt_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ipv4_tx_pkt_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_tx_pkt_arbiter.sv
// rtl/ipv4_tx_pkt_arbiter.sv - packet-granular round-robin merge of UDP and ICMP TX byte streams
module ipv4_tx_pkt_arbiter #(
    parameter int MAX_PKT_BYTES = 1500,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic        i_txmac_clk,
    input  logic        i_txmac_arst,

    input  logic        i_udp_pkt_byte_rdy,
    input  logic [7:0]  i_udp_pkt_byte,
    input  logic        i_udp_pkt_byte_vld,
    input  logic        i_udp_pkt_last_byte,
    output logic        o_udp_pkt_byte_rd,

    input  logic        i_icmp_pkt_byte_rdy,
    input  logic [7:0]  i_icmp_pkt_byte,
    input  logic        i_icmp_pkt_byte_vld,
    input  logic        i_icmp_pkt_last_byte,
    output logic        o_icmp_pkt_byte_rd,

    output logic        o_ipv4_pkt_byte_rdy,
    output logic [7:0]  o_ipv4_pkt_byte,
    output logic        o_ipv4_pkt_byte_vld,
    output logic        o_ipv4_pkt_last_byte,
    input  logic        i_ipv4_pkt_byte_rd,

    output logic [15:0] o_udp_pkt_cnt,
    output logic [15:0] o_icmp_pkt_cnt,
    output logic        o_overlength_err,
    output logic        o_stall_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic        GRANT_UDP   = 1'b0;
    localparam logic        GRANT_ICMP  = 1'b1;
    localparam logic [10:0] BYTE_LIMIT  = 11'(MAX_PKT_BYTES - 1);
    localparam logic [7:0]  STALL_LIMIT = 8'(STALL_TIMEOUT);
    localparam logic [7:0]  STALL_PRE   = 8'(STALL_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic [15:0] udp_cnt_q, udp_cnt_d;
    logic [15:0] icmp_cnt_q, icmp_cnt_d;
    logic        ovl_q, ovl_d;
    logic        stall_q, stall_d;

    logic [7:0]  src_byte;
    logic        src_vld;
    logic        src_last;
    logic        src_rd;
    logic        in_xfer;
    logic        at_limit;

    // Select the granted source's head byte and flags.
    always_comb begin
        if (grant_q == GRANT_ICMP) begin
            src_byte = i_icmp_pkt_byte;
            src_vld  = i_icmp_pkt_byte_vld;
            src_last = i_icmp_pkt_last_byte;
        end else begin
            src_byte = i_udp_pkt_byte;
            src_vld  = i_udp_pkt_byte_vld;
            src_last = i_udp_pkt_last_byte;
        end
    end

    assign in_xfer  = (state_q == ST_XFER);
    assign at_limit = (byte_cnt_q == BYTE_LIMIT);

    // Pop the granted source: downstream-paced in XFER, self-paced while discarding a truncated tail.
    always_comb begin
        src_rd = 1'b0;
        case (state_q)
            ST_XFER:  src_rd = i_ipv4_pkt_byte_rd & src_vld;
            ST_FLUSH: src_rd = src_vld;
            default:  src_rd = 1'b0;
        endcase
    end

    assign o_udp_pkt_byte_rd    = src_rd & (grant_q == GRANT_UDP);
    assign o_icmp_pkt_byte_rd   = src_rd & (grant_q == GRANT_ICMP);

    assign o_ipv4_pkt_byte_rdy  = in_xfer;
    assign o_ipv4_pkt_byte      = in_xfer ? src_byte : 8'h00;
    assign o_ipv4_pkt_byte_vld  = in_xfer & src_vld;
    // The byte at the length limit always closes the packet downstream, truncated or not.
    assign o_ipv4_pkt_last_byte = in_xfer & (src_last | at_limit);

    assign o_udp_pkt_cnt        = udp_cnt_q;
    assign o_icmp_pkt_cnt       = icmp_cnt_q;
    assign o_overlength_err     = ovl_q;
    assign o_stall_err          = stall_q;

    // Next-state logic: grant, byte/stall counting, packet accounting and error pulses.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        byte_cnt_d   = byte_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        udp_cnt_d    = udp_cnt_q;
        icmp_cnt_d   = icmp_cnt_q;
        ovl_d        = 1'b0;
        stall_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                byte_cnt_d  = 11'd0;
                stall_cnt_d = 8'd0;
                if (i_udp_pkt_byte_rdy || i_icmp_pkt_byte_rdy) begin
                    if (i_udp_pkt_byte_rdy && i_icmp_pkt_byte_rdy) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = i_icmp_pkt_byte_rdy;
                    end
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                if (!src_vld) begin
                    if (stall_cnt_q != STALL_LIMIT) begin
                        stall_cnt_d = stall_cnt_q + 8'd1;
                        stall_d     = (stall_cnt_q == STALL_PRE);
                    end
                end else begin
                    stall_cnt_d = 8'd0;
                end

                if (src_rd) begin
                    byte_cnt_d = byte_cnt_q + 11'd1;
                    if (src_last || at_limit) begin
                        if (grant_q == GRANT_UDP) begin
                            udp_cnt_d = udp_cnt_q + 16'd1;
                        end else begin
                            icmp_cnt_d = icmp_cnt_q + 16'd1;
                        end
                        last_grant_d = grant_q;
                        ovl_d        = ~src_last;
                        state_d      = src_last ? ST_IDLE : ST_FLUSH;
                    end
                end
            end

            ST_FLUSH: begin
                if (src_rd && src_last) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge i_txmac_clk or posedge i_txmac_arst) begin
        if (i_txmac_arst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GRANT_UDP;
            last_grant_q <= GRANT_ICMP;
            byte_cnt_q   <= 11'd0;
            stall_cnt_q  <= 8'd0;
            udp_cnt_q    <= 16'd0;
            icmp_cnt_q   <= 16'd0;
            ovl_q        <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            byte_cnt_q   <= byte_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            udp_cnt_q    <= udp_cnt_d;
            icmp_cnt_q   <= icmp_cnt_d;
            ovl_q        <= ovl_d;
            stall_q      <= stall_d;
        end
    end

endmodule

// File: tb/tb_ipv4_tx_pkt_arbiter.sv
// tb/tb_ipv4_tx_pkt_arbiter.sv - self-checking bench for ipv4_tx_pkt_arbiter
module tb_ipv4_tx_pkt_arbiter;

    localparam int MAXB   = 16;
    localparam int STALLT = 8;

    logic        clk  = 1'b0;
    logic        arst = 1'b1;

    logic        u_rdy = 1'b0, u_vld = 1'b0, u_last = 1'b0;
    logic [7:0]  u_byte = 8'h00;
    logic        i_rdy = 1'b0, i_vld = 1'b0, i_last = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        ds_rd = 1'b0;

    logic        o_udp_rd, o_icmp_rd;
    logic        o_rdy, o_vld, o_last;
    logic [7:0]  o_byte;
    logic [15:0] o_ucnt, o_icnt;
    logic        o_ovl, o_stall;

    ipv4_tx_pkt_arbiter #(
        .MAX_PKT_BYTES (MAXB),
        .STALL_TIMEOUT (STALLT)
    ) dut (
        .i_txmac_clk          (clk),
        .i_txmac_arst         (arst),
        .i_udp_pkt_byte_rdy   (u_rdy),
        .i_udp_pkt_byte       (u_byte),
        .i_udp_pkt_byte_vld   (u_vld),
        .i_udp_pkt_last_byte  (u_last),
        .o_udp_pkt_byte_rd    (o_udp_rd),
        .i_icmp_pkt_byte_rdy  (i_rdy),
        .i_icmp_pkt_byte      (i_byte),
        .i_icmp_pkt_byte_vld  (i_vld),
        .i_icmp_pkt_last_byte (i_last),
        .o_icmp_pkt_byte_rd   (o_icmp_rd),
        .o_ipv4_pkt_byte_rdy  (o_rdy),
        .o_ipv4_pkt_byte      (o_byte),
        .o_ipv4_pkt_byte_vld  (o_vld),
        .o_ipv4_pkt_last_byte (o_last),
        .i_ipv4_pkt_byte_rd   (ds_rd),
        .o_udp_pkt_cnt        (o_ucnt),
        .o_icmp_pkt_cnt       (o_icnt),
        .o_overlength_err     (o_ovl),
        .o_stall_err          (o_stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Source FIFOs: {gap cycles before this byte is valid, last, data}
    logic [13:0] uq[$];
    logic [13:0] iq[$];
    int uwait = 0;
    int iwait = 0;
    int rd_mode = 0;
    logic rd_toggle = 1'b0;

    // Reference model state: 0 idle, 1 forwarding, 2 discarding tail
    int m_st = 0;
    int m_cur = 0;
    int m_lg = 1;
    int m_idx = 0;
    int m_run = 0;
    logic [15:0] m_ucnt = 16'd0;
    logic [15:0] m_icnt = 16'd0;
    logic exp_ovl = 1'b0;
    logic exp_stall = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_pkt(input int src, input int len, input int gap_at, input int gap_len, input bit rnd);
        for (int k = 0; k < len; k++) begin
            int g;
            int r;
            logic [13:0] e;
            g = 0;
            if (k == gap_at) begin
                g = gap_len;
            end else if (rnd) begin
                r = $urandom_range(0, 99);
                if (r >= 97) g = $urandom_range(8, 20);
                else if (r >= 85) g = $urandom_range(1, 3);
            end
            e = {5'(g), (k == len - 1), 8'($urandom_range(0, 255))};
            if (src == 0) uq.push_back(e);
            else iq.push_back(e);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        logic [13:0] uh, ih;
        logic cv, cl, pop;
        logic [7:0] cb;
        logic e_rdy, e_vld, e_last, e_urd, e_ird, n_ovl, n_stall;
        logic [7:0] e_byte;

        check_eq("udp_cnt", o_ucnt, m_ucnt);
        check_eq("icmp_cnt", o_icnt, m_icnt);
        check_eq("ovl_err", o_ovl, exp_ovl);
        check_eq("stall_err", o_stall, exp_stall);

        uh = (uq.size() > 0) ? uq[0] : 14'd0;
        ih = (iq.size() > 0) ? iq[0] : 14'd0;
        u_rdy  = (uq.size() > 0);
        u_vld  = (uq.size() > 0) && (uwait >= int'(uh[13:9]));
        u_last = uh[8];
        u_byte = uh[7:0];
        i_rdy  = (iq.size() > 0);
        i_vld  = (iq.size() > 0) && (iwait >= int'(ih[13:9]));
        i_last = ih[8];
        i_byte = ih[7:0];
        case (rd_mode)
            0: ds_rd = 1'b1;
            1: begin rd_toggle = ~rd_toggle; ds_rd = rd_toggle; end
            default: ds_rd = ($urandom_range(0, 3) != 0);
        endcase
        #1;

        cv = (m_cur == 0) ? u_vld : i_vld;
        cl = (m_cur == 0) ? u_last : i_last;
        cb = (m_cur == 0) ? u_byte : i_byte;
        e_rdy = 0; e_vld = 0; e_last = 0; e_byte = 8'h00; e_urd = 0; e_ird = 0;
        n_ovl = 0; n_stall = 0; pop = 0;
        case (m_st)
            0: begin
                if (u_rdy || i_rdy) begin
                    m_cur = (u_rdy && i_rdy) ? (1 - m_lg) : (u_rdy ? 0 : 1);
                    m_st = 1; m_idx = 0; m_run = 0;
                end
            end
            1: begin
                e_rdy = 1; e_vld = cv; e_byte = cb;
                e_last = cl | (m_idx == MAXB - 1);
                pop = ds_rd & cv;
                if (m_cur == 0) e_urd = pop; else e_ird = pop;
                if (!cv) begin
                    if (m_run < STALLT) begin
                        m_run++;
                        if (m_run == STALLT) n_stall = 1;
                    end
                end else begin
                    m_run = 0;
                end
                if (pop) begin
                    if (cl || m_idx == MAXB - 1) begin
                        if (m_cur == 0) m_ucnt++; else m_icnt++;
                        m_lg = m_cur;
                        m_st = cl ? 0 : 2;
                        n_ovl = !cl;
                    end
                    m_idx++;
                end
            end
            default: begin
                if (m_cur == 0) e_urd = cv; else e_ird = cv;
                if (cv && cl) m_st = 0;
            end
        endcase

        check_eq("out_rdy", o_rdy, e_rdy);
        check_eq("out_vld", o_vld, e_vld);
        check_eq("out_last", o_last, e_last);
        check_eq("out_byte", o_byte, e_byte);
        check_eq("udp_rd", o_udp_rd, e_urd);
        check_eq("icmp_rd", o_icmp_rd, e_ird);
        exp_ovl = n_ovl;
        exp_stall = n_stall;

        if (o_udp_rd && uq.size() > 0) begin void'(uq.pop_front()); uwait = 0; end
        else uwait++;
        if (o_icmp_rd && iq.size() > 0) begin void'(iq.pop_front()); iwait = 0; end
        else iwait++;
        @(negedge clk);
    endtask

    task automatic run_until_empty(input int budget);
        int c;
        c = 0;
        while ((uq.size() + iq.size()) > 0 && c < budget) begin
            step();
            c++;
        end
        check_eq("drain_timeout", uq.size() + iq.size(), 0);
        repeat (3) step();
    endtask

    // Entered at a falling edge; asserts reset mid-cycle and releases it at the next falling edge.
    task automatic async_reset();
        #2 arst = 1'b1;
        #1;
        check_eq("rst_rdy", o_rdy, 0);
        check_eq("rst_vld", o_vld, 0);
        check_eq("rst_last", o_last, 0);
        check_eq("rst_byte", o_byte, 0);
        check_eq("rst_udp_rd", o_udp_rd, 0);
        check_eq("rst_icmp_rd", o_icmp_rd, 0);
        check_eq("rst_udp_cnt", o_ucnt, 0);
        check_eq("rst_icmp_cnt", o_icnt, 0);
        check_eq("rst_ovl", o_ovl, 0);
        check_eq("rst_stall", o_stall, 0);
        m_st = 0; m_lg = 1; m_idx = 0; m_run = 0;
        m_ucnt = 16'd0; m_icnt = 16'd0; exp_ovl = 0; exp_stall = 0;
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        async_reset();

        // Tie after reset: UDP first, then strict alternation.
        rd_mode = 0;
        add_pkt(0, 6, -1, 0, 0); add_pkt(0, 7, -1, 0, 0); add_pkt(0, 8, -1, 0, 0);
        add_pkt(1, 5, -1, 0, 0); add_pkt(1, 9, -1, 0, 0); add_pkt(1, 4, -1, 0, 0);
        run_until_empty(200);
        check_eq("tie_udp_total", o_ucnt, 3);
        check_eq("tie_icmp_total", o_icnt, 3);

        // Downstream backpressure on a 10-byte ICMP packet.
        rd_mode = 1;
        add_pkt(1, 10, -1, 0, 0);
        run_until_empty(100);
        check_eq("bp_icmp_total", o_icnt, 4);

        // Overlength UDP followed by a normal ICMP packet.
        rd_mode = 0;
        add_pkt(0, 20, -1, 0, 0);
        add_pkt(1, 10, -1, 0, 0);
        run_until_empty(200);
        check_eq("ovl_udp_total", o_ucnt, 4);
        check_eq("ovl_icmp_total", o_icnt, 5);

        // Packet exactly at the length limit.
        add_pkt(0, MAXB, -1, 0, 0);
        run_until_empty(100);
        check_eq("exact_udp_total", o_ucnt, 5);

        // 20-cycle source stall mid-packet.
        add_pkt(0, 12, 5, 20, 0);
        run_until_empty(200);
        check_eq("stall_udp_total", o_ucnt, 6);

        // Randomized traffic with a reset in the middle.
        rd_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 29) == 0 && (uq.size() + iq.size()) < 80)
                add_pkt($urandom_range(0, 1), $urandom_range(1, 24), -1, 0, 1);
            if (c == 1500) async_reset();
            step();
        end
        run_until_empty(4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
